// File: rtl/fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD
    } fetch_state_e;

    localparam int unsigned FETCH_BYTES     = 4;
    localparam logic [31:0] FETCH_BASE_ADDR = 32'h0100_0000;

endpackage

// File: rtl/insn_byte_assembler.sv
// Four byte slots that build one little-endian instruction word.
module insn_byte_assembler
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        we_i,
    input  logic [1:0]  idx_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o
);

    logic [FETCH_BYTES-1:0][7:0] slot_q;
    logic [FETCH_BYTES-1:0][7:0] slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
            slot_d = '0;
        end else if (we_i) begin
            slot_d[idx_i] = byte_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Slot 0 lands in bits 7:0.
    assign word_o = slot_q;

endmodule

// File: rtl/insn_fetch_unit.sv
// Fetches 32-bit instructions one byte at a time from byte-wide memory and
// presents each word with its PC to decode over valid/ready.
module insn_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        AWIDTH    = 32,
    parameter int unsigned        DWIDTH    = 32,
    parameter logic [AWIDTH-1:0]  BASE_ADDR = AWIDTH'(FETCH_BASE_ADDR)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic              mem_req_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_rvalid_i,
    output logic              insn_valid_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] pc_o,
    input  logic              insn_ready_i,
    output logic              misalign_o
);

    fetch_state_e      state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [1:0]        k_q, k_d;
    logic              drop_q, drop_d;
    logic              misalign_q, misalign_d;
    logic              req;
    logic              byte_we;
    logic              asm_clr;
    logic [31:0]       word;

    assign req = (state_q == FETCH_REQ) && !drop_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        k_d        = k_q;
        drop_d     = drop_q;
        byte_we    = 1'b0;
        asm_clr    = 1'b0;
        misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);

        if (drop_q && mem_rvalid_i) begin
            drop_d = 1'b0;
        end

        case (state_q)
            FETCH_REQ: begin
                if (req) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (mem_rvalid_i) begin
                    byte_we = 1'b1;
                    if (k_q == 2'd3) begin
                        state_d = FETCH_HOLD;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = FETCH_REQ;
                    end
                end
            end
            FETCH_HOLD: begin
                if (insn_ready_i) begin
                    pc_d    = pc_q + AWIDTH'(FETCH_BYTES);
                    k_d     = 2'd0;
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase

        // Only arm drop while a response is still in flight after this edge;
        // a byte landing in the redirect cycle itself is already consumed.
        if (redirect_valid) begin
            pc_d    = {redirect_pc[AWIDTH-1:2], 2'b00};
            k_d     = 2'd0;
            state_d = FETCH_REQ;
            asm_clr = 1'b1;
            drop_d  = req
                   || ((state_q == FETCH_WAIT) && !mem_rvalid_i)
                   || (drop_q && !mem_rvalid_i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH_REQ;
            pc_q       <= BASE_ADDR;
            k_q        <= 2'd0;
            drop_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            k_q        <= k_d;
            drop_q     <= drop_d;
            misalign_q <= misalign_d;
        end
    end

    insn_byte_assembler u_asm (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (asm_clr),
        .we_i   (byte_we),
        .idx_i  (k_q),
        .byte_i (mem_rdata_i),
        .word_o (word)
    );

    // Reset gates the request so every output except pc_o reads zero while held.
    assign mem_req_o    = req && reset;
    assign mem_addr_o   = mem_req_o ? (pc_q + AWIDTH'(k_q)) : '0;
    assign insn_valid_o = (state_q == FETCH_HOLD);
    assign insn_o       = DWIDTH'(word);
    assign pc_o         = pc_q;
    assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Self-checking bench for insn_fetch_unit: directed sequences, a redirect
// vector table and randomized traffic against a word-level fetch model.
module tb_insn_fetch_unit;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk            = 1'b0;
    logic        reset          = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_rdata_i    = '0;
    logic        mem_rvalid_i   = 1'b0;
    logic        insn_valid_o;
    logic [31:0] insn_o;
    logic [31:0] pc_o;
    logic        insn_ready_i   = 1'b0;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    insn_fetch_unit #(
        .AWIDTH    (32),
        .DWIDTH    (32),
        .BASE_ADDR (BASE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .insn_valid_o   (insn_valid_o),
        .insn_o         (insn_o),
        .pc_o           (pc_o),
        .insn_ready_i   (insn_ready_i),
        .misalign_o     (misalign_o)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] b;
        case (a)
            32'h0100_0000: return 8'h13;
            32'h0100_0001: return 8'h05;
            32'h0100_0002: return 8'h45;
            32'h0100_0003: return 8'h06;
            default: begin
                b = a[7:0] * 8'd7;
                return b ^ a[15:8] ^ a[31:24] ^ 8'hA5;
            end
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: one response, mem_lat cycles after the request (or random 1..4).
    int unsigned mem_lat  = 1;
    bit          rand_lat = 1'b0;
    bit          pend     = 1'b0;
    int unsigned cnt      = 0;
    logic [7:0]  pdata    = '0;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            pend         = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
        end else begin
            bit busy;
            busy         = pend;
            mem_rvalid_i = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = pdata;
                    pend         = 1'b0;
                end
            end
            if (mem_req_o) begin
                chk("single_outstanding", {31'd0, busy}, 32'd0);
                pend  = 1'b1;
                cnt   = rand_lat ? $urandom_range(1, 4) : mem_lat;
                pdata = mem_byte(mem_addr_o);
            end
        end
    end

    // Word-level fetch model: the stream of (pc, word) decode should receive.
    logic [31:0] exp_pc   = BASE;
    logic        exp_mis  = 1'b0;
    int          accepted = 0;
    int          cyc      = 0;
    int          hs_cyc   = 0;
    logic [31:0] hs_pc    = '0;
    logic [31:0] hs_insn  = '0;
    logic        s_valid, s_req, s_mis;
    logic [31:0] s_addr;

    task automatic cycle(input bit rdv, input logic [31:0] rpc, input bit rdy);
        @(negedge clk);
        redirect_valid = rdv;
        redirect_pc    = rpc;
        insn_ready_i   = rdy;
        s_valid = insn_valid_o;
        s_req   = mem_req_o;
        s_addr  = mem_addr_o;
        s_mis   = misalign_o;
        chk("misalign", {31'd0, misalign_o}, {31'd0, exp_mis});
        if (insn_valid_o && rdy) begin
            chk("sb_pc", pc_o, exp_pc);
            chk("sb_insn", insn_o, word_at(exp_pc));
            hs_pc   = pc_o;
            hs_insn = insn_o;
            hs_cyc  = cyc;
            accepted++;
            exp_pc  = exp_pc + 32'd4;
        end
        if (rdv) exp_pc = {rpc[31:2], 2'b00};
        exp_mis = rdv && (rpc[1:0] != 2'b00);
        cyc++;
    endtask

    task automatic run_until_hs(input string name, input int budget);
        int start;
        start = accepted;
        for (int i = 0; i < budget; i++) begin
            cycle(1'b0, '0, 1'b1);
            if (accepted != start) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: no word within %0d cycles", name, budget);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, mem_req_o},    32'd0);
        chk({tag, "_addr"},  mem_addr_o,            32'd0);
        chk({tag, "_valid"}, {31'd0, insn_valid_o}, 32'd0);
        chk({tag, "_insn"},  insn_o,                32'd0);
        chk({tag, "_pc"},    pc_o,                  BASE);
        chk({tag, "_mis"},   {31'd0, misalign_o},   32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        exp_pc  = BASE;
        exp_mis = 1'b0;
        cyc     = 0;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        insn_ready_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        release_reset();
    endtask

    typedef struct packed {
        logic [31:0] target;
        logic        mis;
        logic [31:0] first_pc;
        logic [31:0] second_pc;
    } redir_vec_t;

    redir_vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          hcyc [5];
        logic [31:0] hpc  [5];
        int          n;
        int          start_acc;
        bit          found;

        vecs[0] = '{32'h0100_0010, 1'b0, 32'h0100_0010, 32'h0100_0014};
        vecs[1] = '{32'h0100_0006, 1'b1, 32'h0100_0004, 32'h0100_0008};
        vecs[2] = '{32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h0000_0003, 1'b1, 32'h0000_0000, 32'h0000_0004};
        vecs[4] = '{32'h8000_0001, 1'b1, 32'h8000_0000, 32'h8000_0004};

        // First word latency plus five back-to-back words.
        do_reset();
        n = 0;
        for (int i = 0; i < 80 && n < 5; i++) begin
            start_acc = accepted;
            cycle(1'b0, '0, 1'b1);
            if (accepted != start_acc) begin
                hcyc[n] = hs_cyc;
                hpc[n]  = hs_pc;
                if (n == 0) chk("first_insn", hs_insn, 32'h0645_0513);
                n++;
            end
        end
        chk("b2b_count", n, 5);
        chk("first_valid_cycle", hcyc[0], 8);
        for (int i = 0; i < 5; i++) chk("b2b_pc", hpc[i], BASE + 32'(4 * i));
        for (int i = 1; i < 5; i++) chk("b2b_spacing", hcyc[i] - hcyc[i-1], 9);

        // Back-pressure in HOLD.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b0, '0, 1'b0);
            found = s_valid;
        end
        chk("hold_reached", {31'd0, found}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b0);
            chk("hold_valid", {31'd0, s_valid}, 32'd1);
            chk("hold_req",   {31'd0, s_req},   32'd0);
            chk("hold_pc",    pc_o,             BASE);
            chk("hold_insn",  insn_o,           32'h0645_0513);
        end
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("release_valid", {31'd0, s_valid}, 32'd0);
        chk("release_req",   {31'd0, s_req},   32'd1);
        chk("release_addr",  s_addr,           BASE + 32'd4);

        // Redirect while waiting on byte 2 with slow memory.
        mem_lat = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b0, '0, 1'b1);
            found = s_req && (s_addr == BASE + 32'd2);
        end
        chk("wait_byte2_reached", {31'd0, found}, 32'd1);
        cycle(1'b1, 32'h0100_0010, 1'b1);
        run_until_hs("drop_redirect", 80);
        chk("drop_pc",   hs_pc,   32'h0100_0010);
        chk("drop_insn", hs_insn, word_at(32'h0100_0010));
        mem_lat = 1;

        // Redirect vector table: alignment, misalign pulse and PC wrap.
        do_reset();
        foreach (vecs[v]) begin
            cycle(1'b1, vecs[v].target, 1'b1);
            cycle(1'b0, '0, 1'b1);
            chk("tbl_mis_pulse", {31'd0, s_mis}, {31'd0, vecs[v].mis});
            cycle(1'b0, '0, 1'b1);
            chk("tbl_mis_clear", {31'd0, s_mis}, 32'd0);
            run_until_hs("tbl_first", 40);
            chk("tbl_first_pc", hs_pc, vecs[v].first_pc);
            run_until_hs("tbl_second", 40);
            chk("tbl_second_pc", hs_pc, vecs[v].second_pc);
        end

        // Asynchronous reset in the middle of a byte wait.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b0, '0, 1'b1);
            found = s_req && (s_addr == BASE + 32'd1);
        end
        chk("wait_byte1_reached", {31'd0, found}, 32'd1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_reset_outputs("midreset");
        release_reset();
        run_until_hs("after_reset", 40);
        chk("refetch_pc",   hs_pc,   BASE);
        chk("refetch_insn", hs_insn, 32'h0645_0513);

        // Randomized traffic against the word-level model.
        rand_lat = 1'b1;
        do_reset();
        start_acc = accepted;
        for (int i = 0; i < 3000; i++) begin
            bit          rdv;
            bit          rdy;
            logic [31:0] rpc;
            rdy = ($urandom_range(0, 3) != 0);
            rdv = ($urandom_range(0, 39) == 0);
            rpc = $urandom_range(0, 1) ? (BASE + 32'($urandom_range(0, 63))) : 32'($urandom());
            cycle(rdv, rpc, rdy);
        end
        checks++;
        if (accepted - start_acc < 50) begin
            errors++;
            $display("FAIL random_progress: got %0d words expected at least 50", accepted - start_acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
